gprs_sb: RTL and testbench
==========================

Name: gprs_sb

Overview:
Parametrised multi-port general-purpose register file with an integrated busy scoreboard, succeeding the fixed 2R1W register file.
- Supports N read ports, M write ports, configurable width and depth, and optional write-to-read bypass.
- Holds a per-register pending-write (busy) bit, set at issue and cleared at writeback, so decode can detect RAW hazards.
- Sits between decode (read, issue) and writeback (write) in the pipeline.

Parameters:
DATA_W, 32, register data width in bits
NUM_REGS, 32, number of registers (power of two, >=2); ADDR_W = $clog2(NUM_REGS) is derived locally
RD_PORTS, 2, number of read ports (>=1)
WR_PORTS, 2, number of write ports (>=1)
BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return stored value only

Ports:
CLK  in  1  clock, all state updates on rising edge
RST  in  1  asynchronous active-low reset
WE  in  WR_PORTS  per-port write enable, active-high
WADDR  in  WR_PORTS*ADDR_W  write addresses, port k at bits [k*ADDR_W +: ADDR_W]
WDATA  in  WR_PORTS*DATA_W  write data, packed the same way
RE  in  RD_PORTS  per-port read enable, active-high
RADDR  in  RD_PORTS*ADDR_W  read addresses, packed
RDATA  out  RD_PORTS*DATA_W  read data, combinational
RBUSY  out  RD_PORTS  1 = the addressed register has an outstanding write; combinational
ISSUE  in  1  mark ISSUE_ADDR busy at the next edge
ISSUE_ADDR  in  ADDR_W  destination register being issued
FLUSH  in  1  clear all busy bits at the next edge; register contents are untouched
BUSY_ANY  out  1  OR of all busy bits, registered state

Behaviour:
- Reset (RST=0, asynchronous): all registers are 0 and all busy bits are 0.
  - RDATA is 0 for ports with RE=0; otherwise it follows the normal read rules against the zeroed state.
  - RBUSY=0 and BUSY_ANY=0 while in reset.
  - Write, issue and flush inputs are ignored while in reset.
- Register 0 is hardwired:
  - Writes to it are dropped, its busy bit is never set, and reads of it return 0 with RBUSY=0.
  - This holds regardless of BYPASS.
- Write, 1-cycle latency: on a rising edge, for each k with WE[k]=1 and WADDR_k!=0, regs[WADDR_k] <= WDATA_k.
  - If several ports target the same address, the highest-index port wins.
- Read port j:
  - RE[j]=0: RDATA_j=0 and RBUSY_j=0.
  - RE[j]=1 and RADDR_j=0: RDATA_j=0 and RBUSY_j=0.
  - BYPASS=1 and some k has WE[k]=1 with WADDR_k==RADDR_j: RDATA_j = WDATA of the highest such k, and RBUSY_j=0.
  - Otherwise RDATA_j = regs[RADDR_j] and RBUSY_j = busy[RADDR_j].
  - With BYPASS=0, RBUSY_j = busy[RADDR_j] even while a write to that address is in flight.
- Busy bit update per address a (a!=0), evaluated in priority order at each edge:
  1. FLUSH=1: busy[a] <= 0 for all a. ISSUE in the same cycle is ignored.
  2. ISSUE=1 and ISSUE_ADDR==a: busy[a] <= 1. Issue beats a same-cycle writeback to the same address, i.e. a back-to-back redefinition.
  3. Any WE[k]=1 with WADDR_k==a: busy[a] <= 0.
  4. Otherwise busy[a] holds its value.
- ISSUE to address 0 has no effect.
- A write to a non-busy register is legal; it updates data and leaves busy at 0.
- BUSY_ANY reflects the registered busy vector, so it changes one cycle after the causing edge.
- Reset asserted mid-operation clears all state immediately. The first edge after release behaves as from a clean state.

Test Plan:
- Reset then read:
  - Hold RST=0, release, then read r1..r31 on both ports with RE=1.
  - Required: RDATA=0, RBUSY=0 and BUSY_ANY=0 throughout.
- Write/read and r0 protection:
  - Write r5=0xDEADBEEF via port 0 and r0=0x1234 via port 1; next cycle read r5 and r0.
  - Required: 0xDEADBEEF and 0 respectively.
- Same-address write conflict:
  - In one cycle, WE=2'b11 with both ports targeting r7; port 0 data 0x11, port 1 data 0x22.
  - Required: reading r7 next cycle gives 0x22.
  - Same cycle with BYPASS=1: a read of r7 shows 0x22.
- Bypass versus stored value:
  - r3 holds 0xA; write r3=0xB and read r3 in the same cycle.
  - BYPASS=1: required RDATA=0xB, and 0xB on the following cycle.
  - BYPASS=0: required RDATA=0xA, and 0xB on the following cycle.
- Scoreboard lifecycle:
  - ISSUE r9, then read r9.
  - Required: RBUSY=1 from the next cycle and BUSY_ANY=1.
  - Then write r9=0x55 and issue r9 again in the same cycle. Required: r9 stays busy with data 0x55.
  - Then write r9 alone. Required: RBUSY=0 and BUSY_ANY=0 one cycle later.
- Flush and async reset:
  - Issue r2, r4, r6, then assert FLUSH together with ISSUE r8.
  - Required: all busy bits 0 next cycle, r8 not busy, data unchanged.
  - Then issue r10 and drop RST mid-cycle (no edge). Required: RBUSY and RDATA go to 0 immediately.

Source files
------------

// File: rtl/gprs_sb.sv
`default_nettype none
// =============================================================================
// gprs_sb : multi-port register file with per-register pending-write scoreboard
// Rev 1.0 : initial release
// =============================================================================
module gprs_sb #(
  parameter  int DATA_W   = 32,
  parameter  int NUM_REGS = 32,
  parameter  int RD_PORTS = 2,
  parameter  int WR_PORTS = 2,
  parameter  int BYPASS   = 1,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [WR_PORTS-1:0]        WE,
  input  logic [WR_PORTS*ADDR_W-1:0] WADDR,
  input  logic [WR_PORTS*DATA_W-1:0] WDATA,
  input  logic [RD_PORTS-1:0]        RE,
  input  logic [RD_PORTS*ADDR_W-1:0] RADDR,
  output logic [RD_PORTS*DATA_W-1:0] RDATA,
  output logic [RD_PORTS-1:0]        RBUSY,
  input  logic                       ISSUE,
  input  logic [ADDR_W-1:0]          ISSUE_ADDR,
  input  logic                       FLUSH,
  output logic                       BUSY_ANY
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;

  // Later ports are applied last, so the highest-index writer wins a collision.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int a = 0; a < NUM_REGS; a++) regs[a] <= '0;
    end else begin
      for (int k = 0; k < WR_PORTS; k++) begin
        if (WE[k] && (WADDR[k*ADDR_W +: ADDR_W] != '0))
          regs[WADDR[k*ADDR_W +: ADDR_W]] <= WDATA[k*DATA_W +: DATA_W];
      end
    end
  end

  // Applied lowest to highest priority: writeback clear, issue set, flush.
  always_comb begin
    busy_nxt = busy;
    for (int k = 0; k < WR_PORTS; k++) begin
      if (WE[k]) busy_nxt[WADDR[k*ADDR_W +: ADDR_W]] = 1'b0;
    end
    if (ISSUE) busy_nxt[ISSUE_ADDR] = 1'b1;
    if (FLUSH) busy_nxt = '0;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) busy <= '0;
    else      busy <= busy_nxt;
  end

  assign BUSY_ANY = |busy;

  for (genvar j = 0; j < RD_PORTS; j++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    logic              rb;

    assign ra = RADDR[j*ADDR_W +: ADDR_W];

    // Forwarding is suppressed during reset because writes are ignored then.
    always_comb begin
      rd = '0;
      rb = 1'b0;
      if (RE[j] && (ra != '0)) begin
        rd = regs[ra];
        rb = busy[ra];
        if ((BYPASS != 0) && RST) begin
          for (int k = 0; k < WR_PORTS; k++) begin
            if (WE[k] && (WADDR[k*ADDR_W +: ADDR_W] == ra)) begin
              rd = WDATA[k*DATA_W +: DATA_W];
              rb = 1'b0;
            end
          end
        end
      end
    end

    assign RDATA[j*DATA_W +: DATA_W] = rd;
    assign RBUSY[j]                  = rb;
  end

endmodule
`default_nettype wire

// File: tb/tb_gprs_sb.sv
`default_nettype none
// tb_gprs_sb : scoreboard bench driving a BYPASS=1 and a BYPASS=0 instance in parallel.
module tb_gprs_sb;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [1:0]  WE = '0;
  logic [9:0]  WADDR = '0;
  logic [63:0] WDATA = '0;
  logic [1:0]  RE = '0;
  logic [9:0]  RADDR = '0;
  logic        ISSUE = 1'b0;
  logic [4:0]  ISSUE_ADDR = '0;
  logic        FLUSH = 1'b0;

  logic [63:0] rdata_b1, rdata_b0;
  logic [1:0]  rbusy_b1, rbusy_b0;
  logic        busy_any_b1, busy_any_b0;

  gprs_sb #(.DATA_W(32), .NUM_REGS(32), .RD_PORTS(2), .WR_PORTS(2), .BYPASS(1)) dut_b1 (
    .CLK(CLK), .RST(RST), .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
    .RE(RE), .RADDR(RADDR), .RDATA(rdata_b1), .RBUSY(rbusy_b1),
    .ISSUE(ISSUE), .ISSUE_ADDR(ISSUE_ADDR), .FLUSH(FLUSH), .BUSY_ANY(busy_any_b1)
  );

  gprs_sb #(.DATA_W(32), .NUM_REGS(32), .RD_PORTS(2), .WR_PORTS(2), .BYPASS(0)) dut_b0 (
    .CLK(CLK), .RST(RST), .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
    .RE(RE), .RADDR(RADDR), .RDATA(rdata_b0), .RBUSY(rbusy_b0),
    .ISSUE(ISSUE), .ISSUE_ADDR(ISSUE_ADDR), .FLUSH(FLUSH), .BUSY_ANY(busy_any_b0)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       nm;
    logic [63:0] d1;
    logic [63:0] d0;
    logic [1:0]  b1;
    logic [1:0]  b0;
    logic        ba;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state: architectural register contents and pending-write flags.
  bit [31:0] mem [32];
  bit [31:0] pend;

  task automatic chk(input string nm, input string what, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s %s: got %h expected %h", nm, what, act, expv);
    end
  endtask

  always @(negedge CLK) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk(e.nm, "rdata_byp1", rdata_b1, e.d1);
      chk(e.nm, "rbusy_byp1", {62'd0, rbusy_b1}, {62'd0, e.b1});
      chk(e.nm, "busy_any_byp1", {63'd0, busy_any_b1}, {63'd0, e.ba});
      chk(e.nm, "rdata_byp0", rdata_b0, e.d0);
      chk(e.nm, "rbusy_byp0", {62'd0, rbusy_b0}, {62'd0, e.b0});
      chk(e.nm, "busy_any_byp0", {63'd0, busy_any_b0}, {63'd0, e.ba});
    end
  end

  task automatic cyc(input bit rst, input bit [1:0] we, input bit [4:0] wa0, input bit [4:0] wa1,
                     input bit [31:0] wd0, input bit [31:0] wd1, input bit [1:0] re,
                     input bit [4:0] ra0, input bit [4:0] ra1, input bit iss, input bit [4:0] ia,
                     input bit fl, input string nm);
    exp_t      e;
    bit [4:0]  ra [2];
    bit [4:0]  wa [2];
    bit [31:0] wd [2];
    bit [1:0]  wev;
    wev = rst ? we : 2'b00;
    ra[0] = ra0; ra[1] = ra1; wa[0] = wa0; wa[1] = wa1; wd[0] = wd0; wd[1] = wd1;
    @(posedge CLK); #1;
    RST = rst; WE = wev; WADDR = {wa1, wa0}; WDATA = {wd1, wd0};
    RE = re; RADDR = {ra1, ra0}; ISSUE = iss; ISSUE_ADDR = ia; FLUSH = fl;
    if (!rst) begin
      for (int i = 0; i < 32; i++) mem[i] = 0;
      pend = 0;
    end
    e.nm = nm;
    e.ba = |pend;
    for (int j = 0; j < 2; j++) begin
      bit [31:0] v;
      bit        b;
      v = 0; b = 0;
      if (re[j] && ra[j] != 0) begin v = mem[ra[j]]; b = pend[ra[j]]; end
      e.d0[j*32 +: 32] = v; e.b0[j] = b;
      for (int k = 0; k < 2; k++)
        if (re[j] && ra[j] != 0 && wev[k] && wa[k] == ra[j]) begin v = wd[k]; b = 0; end
      e.d1[j*32 +: 32] = v; e.b1[j] = b;
    end
    sb.push_back(e);
    if (rst) begin
      for (int k = 0; k < 2; k++) if (wev[k] && wa[k] != 0) mem[wa[k]] = wd[k];
      if (fl) pend = 0;
      else begin
        for (int k = 0; k < 2; k++) if (wev[k]) pend[wa[k]] = 0;
        if (iss) pend[ia] = 1;
      end
      pend[0] = 0;
    end
  endtask

  function automatic bit [4:0] rnd_addr();
    if ($urandom_range(0, 1) == 1) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 0;
    pend = 0;

    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 2'b11, 5'd1, 5'd2, 1, 5'd3, 0, "in_reset");
    for (int a = 1; a < 32; a++) cyc(1, 0, 0, 0, 0, 0, 2'b11, 5'(a), 5'(32 - a), 0, 0, 0, "reset_read");

    cyc(1, 2'b11, 5'd5, 5'd0, 32'hDEADBEEF, 32'h1234, 2'b00, 0, 0, 0, 0, 0, "wr_r5_r0");
    cyc(1, 0, 0, 0, 0, 0, 2'b11, 5'd5, 5'd0, 0, 0, 0, "rd_r5_r0");

    cyc(1, 2'b11, 5'd7, 5'd7, 32'h11, 32'h22, 2'b01, 5'd7, 0, 0, 0, 0, "same_addr_wr");
    cyc(1, 0, 0, 0, 0, 0, 2'b11, 5'd7, 5'd7, 0, 0, 0, "same_addr_rd");

    cyc(1, 2'b01, 5'd3, 0, 32'hA, 0, 2'b00, 0, 0, 0, 0, 0, "r3_init");
    cyc(1, 2'b10, 0, 5'd3, 0, 32'hB, 2'b11, 5'd3, 5'd3, 0, 0, 0, "bypass_r3");
    cyc(1, 0, 0, 0, 0, 0, 2'b11, 5'd3, 5'd3, 0, 0, 0, "after_r3");

    cyc(1, 0, 0, 0, 0, 0, 2'b01, 5'd9, 0, 1, 5'd9, 0, "issue_r9");
    cyc(1, 0, 0, 0, 0, 0, 2'b01, 5'd9, 0, 0, 0, 0, "r9_busy");
    cyc(1, 2'b01, 5'd9, 0, 32'h55, 0, 2'b01, 5'd9, 0, 1, 5'd9, 0, "wr_issue_r9");
    cyc(1, 0, 0, 0, 0, 0, 2'b11, 5'd9, 5'd9, 0, 0, 0, "r9_rebusy");
    cyc(1, 2'b10, 0, 5'd9, 0, 32'h66, 2'b00, 0, 0, 0, 0, 0, "wb_r9");
    cyc(1, 0, 0, 0, 0, 0, 2'b11, 5'd9, 5'd9, 0, 0, 0, "r9_free");

    cyc(1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 5'd2, 0, "issue_r2");
    cyc(1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1, 5'd4, 0, "issue_r4");
    cyc(1, 0, 0, 0, 0, 0, 2'b11, 5'd2, 5'd4, 1, 5'd6, 0, "issue_r6");
    cyc(1, 0, 0, 0, 0, 0, 2'b11, 5'd6, 5'd8, 1, 5'd8, 1, "flush_issue");
    cyc(1, 0, 0, 0, 0, 0, 2'b11, 5'd8, 5'd5, 0, 0, 0, "after_flush");
    cyc(1, 0, 0, 0, 0, 0, 2'b11, 5'd2, 5'd3, 1, 5'd10, 0, "issue_r10");
    cyc(1, 0, 0, 0, 0, 0, 2'b11, 5'd10, 5'd5, 0, 0, 0, "r10_busy");
    cyc(0, 0, 0, 0, 0, 0, 2'b11, 5'd10, 5'd5, 0, 0, 0, "async_reset");
    cyc(1, 0, 0, 0, 0, 0, 2'b11, 5'd10, 5'd5, 0, 0, 0, "post_reset");

    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 63) != 0), 2'($urandom), rnd_addr(), rnd_addr(), $urandom, $urandom,
          2'($urandom), rnd_addr(), rnd_addr(), ($urandom_range(0, 2) == 0), rnd_addr(),
          ($urandom_range(0, 15) == 0), "random");
    end

    @(negedge CLK); #1;
    chk("drain", "queue_left", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
